// File: rtl/midi_message_parser_if.sv
// rtl/midi_message_parser_if.sv - message word type and the byte-in / message-out bus
package midi_message_parser_pkg;

   // One decoded channel message as seen by the dispatcher
   typedef struct packed {
      logic [3:0] message_type;
      logic [3:0] channel;
      logic [6:0] data_byte1;
      logic [6:0] data_byte2;
   } message_t;

endpackage

interface midi_message_parser_if;
   import midi_message_parser_pkg::*;

   logic [7:0] rx_byte;
   logic       rx_valid;
   message_t   message;
   logic       message_ready;
   logic [7:0] error_count;

   modport master (
      output rx_byte,
      output rx_valid,
      input  message,
      input  message_ready,
      input  error_count
   );

   modport slave (
      input  rx_byte,
      input  rx_valid,
      output message,
      output message_ready,
      output error_count
   );

endinterface

// File: rtl/midi_message_parser.sv
// rtl/midi_message_parser.sv - MIDI byte stream to channel message parser (option: MIDI_VELOCITY_ZERO_NOTE_OFF_EN)
module midi_message_parser
   import midi_message_parser_pkg::*;
#(
   parameter bit         OMNI    = 1'b1,
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic                  clock_50_000_000,
   input  logic                  reset,
   midi_message_parser_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2,
      SYSEX   = 2'd3
   } state_t;

   state_t     state_q,         state_d;
   logic [3:0] status_type_q,   status_type_d;
   logic [3:0] status_chan_q,   status_chan_d;
   // Set from a status byte until its first message completes; lets WAIT_D1
   // tell a fresh (incomplete) status apart from retained running status.
   logic       pending_q,       pending_d;
   logic [6:0] data1_q,         data1_d;
   message_t   message_q,       message_d;
   logic       message_ready_q, message_ready_d;
   logic [7:0] error_count_q,   error_count_d;

   logic       incomplete;
   logic       complete;
   logic       bump_error;
   message_t   done_msg;
   logic [7:0] b;

   // Next-state decode of one received byte
   always_comb begin
      state_d         = state_q;
      status_type_d   = status_type_q;
      status_chan_d   = status_chan_q;
      pending_d       = pending_q;
      data1_d         = data1_q;
      message_d       = message_q;
      message_ready_d = 1'b0;
      error_count_d   = error_count_q;
      complete        = 1'b0;
      bump_error      = 1'b0;
      done_msg        = '0;
      b               = bus.rx_byte;
      incomplete      = (state_q == WAIT_D2) || ((state_q == WAIT_D1) && pending_q);

      if (bus.rx_valid) begin
         if (b >= 8'hF8) begin
            // real-time bytes are transparent everywhere
         end else if ((b >= 8'h80) && (b <= 8'hEF)) begin
            bump_error    = incomplete;
            status_type_d = b[7:4];
            status_chan_d = b[3:0];
            pending_d     = 1'b1;
            state_d       = WAIT_D1;
         end else if (b == 8'hF0) begin
            pending_d = 1'b0;
            state_d   = SYSEX;
         end else if (b[7]) begin
            // 0xF1-0xF7: inside SysEx only the terminator matters
            if (state_q == SYSEX) begin
               if (b == 8'hF7) begin
                  state_d = IDLE;
               end
            end else begin
               pending_d = 1'b0;
               state_d   = IDLE;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  bump_error = 1'b1;
               end
               WAIT_D1: begin
                  data1_d = b[6:0];
                  if ((status_type_q == 4'hC) || (status_type_q == 4'hD)) begin
                     complete            = 1'b1;
                     done_msg.data_byte1 = b[6:0];
                     done_msg.data_byte2 = 7'h00;
                  end else begin
                     state_d = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  complete            = 1'b1;
                  done_msg.data_byte1 = data1_q;
                  done_msg.data_byte2 = b[6:0];
               end
               default: begin
                  // SYSEX payload is dropped silently
               end
            endcase
         end
      end

      if (complete) begin
         done_msg.message_type = status_type_q;
         done_msg.channel      = status_chan_q;
`ifdef MIDI_VELOCITY_ZERO_NOTE_OFF_EN
         if ((done_msg.message_type == 4'h9) && (done_msg.data_byte2 == 7'h00)) begin
            done_msg.message_type = 4'h8;
            done_msg.data_byte2   = 7'h40;
         end
`else
         // NOTE_ON with zero velocity passes through unchanged
`endif
         // running status: stay ready for the next data byte
         state_d   = WAIT_D1;
         pending_d = 1'b0;
         if (OMNI || (status_chan_q == CHANNEL)) begin
            message_d       = done_msg;
            message_ready_d = 1'b1;
         end
      end

      if (bump_error && (error_count_q != 8'hFF)) begin
         error_count_d = error_count_q + 8'd1;
      end
   end

   // Parser state and registered outputs
   always_ff @(posedge clock_50_000_000 or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         status_type_q   <= 4'h0;
         status_chan_q   <= 4'h0;
         pending_q       <= 1'b0;
         data1_q         <= 7'h00;
         message_q       <= '0;
         message_ready_q <= 1'b0;
         error_count_q   <= 8'h00;
      end else begin
         state_q         <= state_d;
         status_type_q   <= status_type_d;
         status_chan_q   <= status_chan_d;
         pending_q       <= pending_d;
         data1_q         <= data1_d;
         message_q       <= message_d;
         message_ready_q <= message_ready_d;
         error_count_q   <= error_count_d;
      end
   end

   assign bus.message       = message_q;
   assign bus.message_ready = message_ready_q;
   assign bus.error_count   = error_count_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// tb/tb_midi_message_parser.sv - randomized bench for midi_message_parser against a byte-level model
module tb_midi_message_parser;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic [7:0] rx_byte  = 8'h00;
   logic       rx_valid = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   always #10 clk = ~clk;

   midi_message_parser_if if0 ();
   midi_message_parser_if if1 ();

   assign if0.rx_byte  = rx_byte;
   assign if0.rx_valid = rx_valid;
   assign if1.rx_byte  = rx_byte;
   assign if1.rx_valid = rx_valid;

   midi_message_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_omni (
      .clock_50_000_000 (clk),
      .reset            (rst),
      .bus              (if0)
   );

   midi_message_parser #(.OMNI(1'b0), .CHANNEL(4'd3)) dut_ch3 (
      .clock_50_000_000 (clk),
      .reset            (rst),
      .bus              (if1)
   );

   // reference model: what the byte stream means, not how the parser is built
   bit          m_have;
   logic [7:0]  m_status;
   bit          m_pend;
   logic [6:0]  m_data[2];
   int          m_nd;
   bit          m_sx;
   int          m_err;
   bit          m_emit;
   logic [3:0]  m_ch;
   logic [21:0] m_msg;
   logic [21:0] last0, last1;
   bit          exp_rdy0, exp_rdy1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_have = 0; m_status = 8'h00; m_pend = 0; m_nd = 0; m_sx = 0; m_err = 0;
      m_emit = 0; m_ch = 4'h0; m_msg = '0; last0 = '0; last1 = '0;
   endtask

   task automatic model_err();
      if (m_err < 255) m_err++;
   endtask

   task automatic model_byte(input logic [7:0] bv);
      logic [3:0] ty;
      logic [6:0] d2;
      int need;
      m_emit = 0;
      if (bv >= 8'hF8) return;
      if (bv >= 8'h80 && bv <= 8'hEF) begin
         if (m_have && (m_pend || m_nd > 0)) model_err();
         m_have = 1; m_status = bv; m_pend = 1; m_nd = 0; m_sx = 0;
         return;
      end
      if (bv == 8'hF0) begin
         m_sx = 1; m_have = 0; m_pend = 0; m_nd = 0;
         return;
      end
      if (bv >= 8'hF1) begin
         if (m_sx) begin
            if (bv == 8'hF7) m_sx = 0;
         end else begin
            m_have = 0; m_pend = 0; m_nd = 0;
         end
         return;
      end
      if (m_sx) return;
      if (!m_have) begin
         model_err();
         return;
      end
      m_data[m_nd] = bv[6:0];
      m_nd++;
      ty   = m_status[7:4];
      need = (ty == 4'hC || ty == 4'hD) ? 1 : 2;
      if (m_nd == need) begin
         d2 = (need == 2) ? m_data[1] : 7'h00;
`ifdef MIDI_VELOCITY_ZERO_NOTE_OFF_EN
         if (ty == 4'h9 && d2 == 7'h00) begin
            ty = 4'h8;
            d2 = 7'h40;
         end
`endif
         m_ch   = m_status[3:0];
         m_msg  = {ty, m_ch, m_data[0], d2};
         m_emit = 1;
         m_nd   = 0;
         m_pend = 0;
      end
   endtask

   task automatic step(input bit v, input logic [7:0] bv);
      rx_valid = v;
      rx_byte  = bv;
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      m_emit   = 0;
      if (v) model_byte(bv);
      exp_rdy0 = m_emit;
      exp_rdy1 = m_emit && (m_ch == 4'd3);
      if (exp_rdy0) last0 = m_msg;
      if (exp_rdy1) last1 = m_msg;
      check("rdy_omni", 32'(if0.message_ready), 32'(exp_rdy0));
      check("msg_omni", 32'(if0.message), 32'(last0));
      check("err_omni", 32'(if0.error_count), 32'(m_err));
      check("rdy_ch3", 32'(if1.message_ready), 32'(exp_rdy1));
      check("msg_ch3", 32'(if1.message), 32'(last1));
      check("err_ch3", 32'(if1.error_count), 32'(m_err));
   endtask

   task automatic send(input logic [7:0] bv);
      step(1'b1, bv);
   endtask

   function automatic logic [7:0] rand_byte(output bit v);
      int r;
      r = $urandom_range(0, 99);
      v = 1'b1;
      if (r < 45)      return ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
      else if (r < 70) return 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 80) return 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 84) return 8'hF0;
      else if (r < 90) return 8'hF7;
      else if (r < 93) return 8'($urandom_range(8'hF1, 8'hF6));
      v = 1'b0;
      return 8'h00;
   endfunction

   initial begin
      bit         v;
      logic [7:0] bv;
      model_reset();

      // reset values
      @(negedge clk);
      check("rst_msg", 32'(if0.message), 32'h0);
      check("rst_rdy", 32'(if0.message_ready), 32'h0);
      check("rst_err", 32'(if0.error_count), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // basic message and running status
      send(8'h90); send(8'h3C); send(8'h64);
      check("tp_note_on", 32'(if0.message), 32'({4'h9, 4'h0, 7'h3C, 7'h64}));
      send(8'h3E); send(8'h50);
      check("tp_running", 32'(if0.message), 32'({4'h9, 4'h0, 7'h3E, 7'h50}));
      check("tp_running_err", 32'(if0.error_count), 32'h0);

      // real-time interleave
      send(8'h91); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
      check("tp_realtime", 32'(if0.message), 32'({4'h9, 4'h1, 7'h3C, 7'h64}));

      // one data byte
      send(8'hC2); send(8'h05);
      check("tp_one_byte", 32'(if0.message), 32'({4'hC, 4'h2, 7'h05, 7'h00}));

      // SysEx then orphan data
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h64);
      check("tp_sysex_err", 32'(if0.error_count), 32'd2);
      check("tp_sysex_hold", 32'(if0.message), 32'({4'hC, 4'h2, 7'h05, 7'h00}));

      // abort mid-message
      send(8'h90); send(8'h3C); send(8'h80); send(8'h40); send(8'h40);
      check("tp_abort_msg", 32'(if0.message), 32'({4'h8, 4'h0, 7'h40, 7'h40}));
      check("tp_abort_err", 32'(if0.error_count), 32'd3);

      // channel filter and zero velocity
      send(8'h92); send(8'h3C); send(8'h64);
      check("tp_filtered", 32'(if1.message), 32'h0);
      send(8'h93); send(8'h3C); send(8'h00);
`ifdef MIDI_VELOCITY_ZERO_NOTE_OFF_EN
      check("tp_vel0", 32'(if1.message), 32'({4'h8, 4'h3, 7'h3C, 7'h40}));
`else
      check("tp_vel0", 32'(if1.message), 32'({4'h9, 4'h3, 7'h3C, 7'h00}));
`endif

      // reset in the middle of a message
      send(8'h90); send(8'h3C);
      rst = 1'b1;
      #3;
      model_reset();
      check("mid_rst_msg", 32'(if0.message), 32'h0);
      check("mid_rst_rdy", 32'(if0.message_ready), 32'h0);
      check("mid_rst_err", 32'(if0.error_count), 32'h0);
      check("mid_rst_msg1", 32'(if1.message), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      send(8'h64);

      // randomized stream, back-to-back with occasional idle cycles
      for (int i = 0; i < 2000; i++) begin
         bv = rand_byte(v);
         step(v, bv);
      end

      // error counter saturation
      send(8'hF1);
      for (int i = 0; i < 300; i++) send(8'h11);
      check("sat_err", 32'(if0.error_count), 32'd255);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/midi_message_parser.md
Name: midi_message_parser

Overview:
- Converts the raw MIDI byte stream from the UART receiver into complete `message_t` words with a one-cycle `message_ready` strobe.
- Sits directly upstream of the dispatcher, which consumes `message` / `message_ready`.
- Handles running status, interleaved real-time bytes, SysEx skipping, 1- and 2-data-byte channel messages, and optional channel filtering.

Parameters:
- OMNI, 1, 1 = accept all 16 channels; 0 = accept only CHANNEL.
- CHANNEL, 0, 4-bit MIDI channel accepted when OMNI = 0.

Ports:
- clock_50_000_000  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_byte  input  8  received byte from the UART receiver.
- rx_valid  input  1  rx_byte valid for exactly this cycle.
- message  output  message_t  fields: message_type (status high nibble), channel (4), data_byte1 (7), data_byte2 (7).
- message_ready  output  1  one-cycle strobe; `message` is valid during it.
- error_count  output  8  count of discarded/aborted bytes; saturates at 255.

Behaviour:
- Reset values:
  - message = '0, message_ready = 0, error_count = 0.
  - state = IDLE, running status cleared.
- Byte classes, evaluated only when rx_valid = 1:
  - Real-time, 0xF8–0xFF: ignored completely; state unchanged in every state, including mid-message and SYSEX.
  - Channel status, 0x80–0xEF: latch the status byte, go to WAIT_D1. If the current message is incomplete, abort it and increment error_count.
  - 0xF0: go to SYSEX and clear running status.
  - 0xF1–0xF7 outside SYSEX: clear running status, go to IDLE.
  - Data byte, 0x00–0x7F: handled per state, below.
- States and transitions:
  - IDLE: data byte → discard, error_count++.
  - WAIT_D1: data byte → latch data_byte1.
    - Status 0xC or 0xD (one data byte): complete the message, with data_byte2 = 0.
    - Otherwise: go to WAIT_D2.
  - WAIT_D2: data byte → latch data_byte2 and complete the message.
  - SYSEX: every byte except real-time is dropped, with no error count. 0xF7 → IDLE. A channel status byte also exits SYSEX (handled as above).
- Message completion:
  - The state returns to WAIT_D1 with the latched status retained (running status), so the next data byte starts a new message.
  - If OMNI = 1 or channel == CHANNEL: on the next clock edge drive `message` and pulse message_ready for one cycle.
  - Otherwise: drop the message silently; running status is still retained.
- Latency and hold:
  - message_ready rises exactly 1 cycle after the rx_valid cycle of the final byte.
  - `message` holds its value until the next accepted message.
- Back-to-back: consecutive rx_valid cycles are legal; the parser sustains one byte per cycle with no stalls and has no ready output.
- Reset mid-message: the partial message is discarded, no strobe is issued, and running status is lost.
- error_count saturates at 255 and never wraps.

Optional Feature:
- Macro: MIDI_VELOCITY_ZERO_NOTE_OFF_EN.
- Defined: a completed NOTE_ON (0x9) with data_byte2 == 0 is emitted with message_type = NOTE_OFF (0x8) and data_byte2 = 0x40. Channel and data_byte1 are unchanged.
- Undefined: NOTE_ON with velocity 0 is passed through unmodified.

Test Plan:
- Bytes 90 3C 64 on consecutive cycles → one strobe 1 cycle after 0x64, with message_type = 0x9, channel = 0, data_byte1 = 0x3C, data_byte2 = 0x64.
- Running status: after 90 3C 64, send 3E 50 → second strobe with message_type = 0x9, data_byte1 = 0x3E, data_byte2 = 0x50. error_count stays 0.
- Real-time interleave: 91 F8 3C FE 64 → single strobe with channel = 1, data_byte1 = 0x3C, data_byte2 = 0x64. Both F8 and FE are ignored.
- One-data-byte message: C2 05 → strobe after 0x05 with message_type = 0xC, channel = 2, data_byte1 = 0x05, data_byte2 = 0x00.
- SysEx and abort:
  - F0 01 02 F7 3C 64 → no strobe, error_count = 2.
  - 90 3C 80 40 40 → one strobe for the NOTE_OFF (data_byte1 = 0x40, data_byte2 = 0x40), error_count = 3.
- Filter, velocity-zero and reset:
  - OMNI = 0, CHANNEL = 3: 92 3C 64 → no strobe; 93 3C 00 → strobe with NOTE_OFF and data_byte2 = 0x40 when the macro is defined, NOTE_ON and data_byte2 = 0x00 when undefined.
  - Assert reset between 3C and 64 → no strobe, and all outputs return to 0.
